// File: rtl/trigger_cmd_writer.sv
// Turns a host command byte stream into single-beat config bus writes and
// one-byte control strobes. Partial frames are dropped after an idle timeout.
module trigger_cmd_writer #(
   parameter int unsigned BAW = 6,
   parameter int unsigned BDW = 32,
   parameter int unsigned TOW = 16,
   parameter int unsigned TOC = 1000
) (
   input  logic           clk,
   input  logic           rst,
   output logic           sti_tready,
   input  logic           sti_tvalid,
   input  logic [7:0]     sti_tdata,
   input  logic           bus_wready,
   output logic           bus_wvalid,
   output logic [BAW-1:0] bus_waddr,
   output logic [BDW-1:0] bus_wdata,
   output logic           cmd_valid,
   output logic [6:0]     cmd_code,
   output logic           err_timeout
);

   localparam int unsigned NB = BDW / 8;
   localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;

   typedef enum logic [1:0] {StIdle, StData, StWrite} state_e;

   state_e         state_q, state_d;
   logic [CW-1:0]  count_q, count_d;
   logic [TOW-1:0] timer_q, timer_d;
   logic [BAW-1:0] waddr_q, waddr_d;
   logic [BDW-1:0] wdata_q, wdata_d;
   logic           wvalid_q, wvalid_d;
   logic           cmd_valid_q, cmd_valid_d;
   logic [6:0]     cmd_code_q, cmd_code_d;
   logic           err_q, err_d;

   logic byte_xfer, bus_xfer, timeout_hit;

   assign sti_tready  = (state_q != StWrite);
   assign byte_xfer   = sti_tvalid & sti_tready;
   assign bus_xfer    = wvalid_q & bus_wready;
   // A byte arriving on the expiry cycle wins over the timeout.
   assign timeout_hit = (TOC != 0) && (state_q == StData) && !byte_xfer &&
                        (timer_q == TOW'(TOC - 1));

   assign bus_wvalid  = wvalid_q;
   assign bus_waddr   = waddr_q;
   assign bus_wdata   = wdata_q;
   assign cmd_valid   = cmd_valid_q;
   assign cmd_code    = cmd_code_q;
   assign err_timeout = err_q;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      timer_d     = '0;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      wvalid_d    = wvalid_q;
      cmd_valid_d = 1'b0;
      cmd_code_d  = cmd_code_q;
      err_d       = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (byte_xfer) begin
               if (sti_tdata[7]) begin
                  waddr_d = sti_tdata[BAW-1:0];
                  count_d = '0;
                  wdata_d = '0;
                  state_d = StData;
               end else begin
                  cmd_valid_d = 1'b1;
                  cmd_code_d  = sti_tdata[6:0];
               end
            end
         end
         StData: begin
            if (byte_xfer) begin
               wdata_d[8*count_q +: 8] = sti_tdata;
               count_d = count_q + CW'(1);
               if (count_q == CW'(NB - 1)) begin
                  state_d  = StWrite;
                  wvalid_d = 1'b1;
               end
            end else if (timeout_hit) begin
               state_d = StIdle;
               err_d   = 1'b1;
            end else begin
               timer_d = timer_q + TOW'(1);
            end
         end
         StWrite: begin
            if (bus_xfer) begin
               wvalid_d = 1'b0;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         count_q     <= '0;
         timer_q     <= '0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         wvalid_q    <= 1'b0;
         cmd_valid_q <= 1'b0;
         cmd_code_q  <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         timer_q     <= timer_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         wvalid_q    <= wvalid_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_code_q  <= cmd_code_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_trigger_cmd_writer.sv
// Directed per-cycle vectors for trigger_cmd_writer (BDW=32, BAW=6, TOC=8).
module tb_trigger_cmd_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic        sti_tready, sti_tvalid;
   logic [7:0]  sti_tdata;
   logic        bus_wready, bus_wvalid;
   logic [5:0]  bus_waddr;
   logic [31:0] bus_wdata;
   logic        cmd_valid, err_timeout;
   logic [6:0]  cmd_code;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      bit          rst;
      bit          tv;
      logic [7:0]  d;
      bit          wr;
      bit          e_tr;
      bit          e_wv;
      logic [5:0]  e_addr;
      logic [31:0] e_data;
      bit          e_cv;
      logic [6:0]  e_code;
      bit          e_err;
   } vec_t;

   vec_t tbl[$];

   trigger_cmd_writer #(.BAW(6), .BDW(32), .TOW(16), .TOC(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .sti_tready (sti_tready),
      .sti_tvalid (sti_tvalid),
      .sti_tdata  (sti_tdata),
      .bus_wready (bus_wready),
      .bus_wvalid (bus_wvalid),
      .bus_waddr  (bus_waddr),
      .bus_wdata  (bus_wdata),
      .cmd_valid  (cmd_valid),
      .cmd_code   (cmd_code),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(bit r, bit tv, logic [7:0] d, bit wr, bit etr, bit ewv,
                               logic [5:0] ea, logic [31:0] ed, bit ecv, logic [6:0] ec,
                               bit eerr);
      vec_t v;
      v.rst = r; v.tv = tv; v.d = d; v.wr = wr;
      v.e_tr = etr; v.e_wv = ewv; v.e_addr = ea; v.e_data = ed;
      v.e_cv = ecv; v.e_code = ec; v.e_err = eerr;
      return v;
   endfunction

   // Inputs are driven mid-cycle; outputs observed just after, before the next posedge.
   task automatic apply(string name, vec_t v);
      bit bad;
      @(negedge clk);
      rst        = v.rst;
      sti_tvalid = v.tv;
      sti_tdata  = v.d;
      bus_wready = v.wr;
      #1;
      n_vec++;
      bad = (sti_tready !== v.e_tr) || (bus_wvalid !== v.e_wv) ||
            (bus_waddr !== v.e_addr) || (bus_wdata !== v.e_data) ||
            (cmd_valid !== v.e_cv) || (err_timeout !== v.e_err) ||
            (v.e_cv && (cmd_code !== v.e_code));
      if (bad) begin
         n_bad++;
         $display("FAIL %s: got tr=%b wv=%b a=%h d=%h cv=%b code=%h err=%b, want tr=%b wv=%b a=%h d=%h cv=%b code=%h err=%b",
                  name, sti_tready, bus_wvalid, bus_waddr, bus_wdata, cmd_valid, cmd_code,
                  err_timeout, v.e_tr, v.e_wv, v.e_addr, v.e_data, v.e_cv, v.e_code, v.e_err);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1);
   end

   initial begin
      // Frame 85 78 56 34 12 with wready=1, then short commands.
      tbl.push_back(mk(1,1,8'h85,1, 1,0,6'h00,32'h0000_0000, 0,7'h00,0));
      tbl.push_back(mk(1,1,8'h78,1, 1,0,6'h05,32'h0000_0000, 0,7'h00,0));
      tbl.push_back(mk(1,1,8'h56,1, 1,0,6'h05,32'h0000_0078, 0,7'h00,0));
      tbl.push_back(mk(1,1,8'h34,1, 1,0,6'h05,32'h0000_5678, 0,7'h00,0));
      tbl.push_back(mk(1,1,8'h12,1, 1,0,6'h05,32'h0034_5678, 0,7'h00,0));
      tbl.push_back(mk(1,0,8'h00,1, 0,1,6'h05,32'h1234_5678, 0,7'h00,0));
      tbl.push_back(mk(1,1,8'h11,1, 1,0,6'h05,32'h1234_5678, 0,7'h00,0));
      tbl.push_back(mk(1,0,8'h00,1, 1,0,6'h05,32'h1234_5678, 1,7'h11,0));
      tbl.push_back(mk(1,1,8'h22,1, 1,0,6'h05,32'h1234_5678, 0,7'h00,0));
      tbl.push_back(mk(1,1,8'h7F,1, 1,0,6'h05,32'h1234_5678, 1,7'h22,0));
      tbl.push_back(mk(1,0,8'h00,1, 1,0,6'h05,32'h1234_5678, 1,7'h7F,0));
      tbl.push_back(mk(1,0,8'h00,1, 1,0,6'h05,32'h1234_5678, 0,7'h00,0));
      // Two back-to-back frames, tvalid held; second header FF keeps only addr 3F.
      tbl.push_back(mk(1,1,8'h81,1, 1,0,6'h05,32'h1234_5678, 0,7'h00,0));
      tbl.push_back(mk(1,1,8'hDD,1, 1,0,6'h01,32'h0000_0000, 0,7'h00,0));
      tbl.push_back(mk(1,1,8'hCC,1, 1,0,6'h01,32'h0000_00DD, 0,7'h00,0));
      tbl.push_back(mk(1,1,8'hBB,1, 1,0,6'h01,32'h0000_CCDD, 0,7'h00,0));
      tbl.push_back(mk(1,1,8'hAA,1, 1,0,6'h01,32'h00BB_CCDD, 0,7'h00,0));
      tbl.push_back(mk(1,1,8'hFF,1, 0,1,6'h01,32'hAABB_CCDD, 0,7'h00,0));
      tbl.push_back(mk(1,1,8'hFF,1, 1,0,6'h01,32'hAABB_CCDD, 0,7'h00,0));
      tbl.push_back(mk(1,1,8'h44,1, 1,0,6'h3F,32'h0000_0000, 0,7'h00,0));
      tbl.push_back(mk(1,1,8'h33,1, 1,0,6'h3F,32'h0000_0044, 0,7'h00,0));
      tbl.push_back(mk(1,1,8'h22,1, 1,0,6'h3F,32'h0000_3344, 0,7'h00,0));
      tbl.push_back(mk(1,1,8'h11,1, 1,0,6'h3F,32'h0022_3344, 0,7'h00,0));
      tbl.push_back(mk(1,0,8'h00,1, 0,1,6'h3F,32'h1122_3344, 0,7'h00,0));
      tbl.push_back(mk(1,0,8'h00,1, 1,0,6'h3F,32'h1122_3344, 0,7'h00,0));

      rst = 1'b0; sti_tvalid = 1'b0; sti_tdata = '0; bus_wready = 1'b0;
      repeat (2) @(negedge clk);

      foreach (tbl[i]) apply($sformatf("tbl%0d", i), tbl[i]);

      // Bus backpressure: WRITE holds for 10 cycles, presented C0 waits.
      apply("bp_hdr", mk(1,1,8'h85,0, 1,0,6'h3F,32'h1122_3344, 0,7'h00,0));
      apply("bp_b0",  mk(1,1,8'h78,0, 1,0,6'h05,32'h0000_0000, 0,7'h00,0));
      apply("bp_b1",  mk(1,1,8'h56,0, 1,0,6'h05,32'h0000_0078, 0,7'h00,0));
      apply("bp_b2",  mk(1,1,8'h34,0, 1,0,6'h05,32'h0000_5678, 0,7'h00,0));
      apply("bp_b3",  mk(1,1,8'h12,0, 1,0,6'h05,32'h0034_5678, 0,7'h00,0));
      for (int k = 0; k < 10; k++)
         apply($sformatf("bp_hold%0d", k), mk(1,1,8'hC0,0, 0,1,6'h05,32'h1234_5678, 0,7'h00,0));
      apply("bp_xfer", mk(1,1,8'hC0,1, 0,1,6'h05,32'h1234_5678, 0,7'h00,0));
      apply("bp_c0",   mk(1,1,8'hC0,1, 1,0,6'h05,32'h1234_5678, 0,7'h00,0));
      apply("bp_n0",   mk(1,1,8'h01,1, 1,0,6'h00,32'h0000_0000, 0,7'h00,0));
      apply("bp_n1",   mk(1,1,8'h02,1, 1,0,6'h00,32'h0000_0001, 0,7'h00,0));
      apply("bp_n2",   mk(1,1,8'h03,1, 1,0,6'h00,32'h0000_0201, 0,7'h00,0));
      apply("bp_n3",   mk(1,1,8'h04,1, 1,0,6'h00,32'h0003_0201, 0,7'h00,0));
      apply("bp_nwr",  mk(1,0,8'h00,1, 0,1,6'h00,32'h0403_0201, 0,7'h00,0));
      apply("bp_nend", mk(1,0,8'h00,1, 1,0,6'h00,32'h0403_0201, 0,7'h00,0));

      // Timeout after 8 idle cycles mid-frame, then a clean frame.
      apply("to_hdr", mk(1,1,8'h83,1, 1,0,6'h00,32'h0403_0201, 0,7'h00,0));
      apply("to_aa",  mk(1,1,8'hAA,1, 1,0,6'h03,32'h0000_0000, 0,7'h00,0));
      for (int k = 0; k < 8; k++)
         apply($sformatf("to_idle%0d", k), mk(1,0,8'h00,1, 1,0,6'h03,32'h0000_00AA, 0,7'h00,0));
      apply("to_err", mk(1,1,8'h81,1, 1,0,6'h03,32'h0000_00AA, 0,7'h00,1));
      apply("to_f0",  mk(1,1,8'h01,1, 1,0,6'h01,32'h0000_0000, 0,7'h00,0));
      apply("to_f1",  mk(1,1,8'h00,1, 1,0,6'h01,32'h0000_0001, 0,7'h00,0));
      apply("to_f2",  mk(1,1,8'h00,1, 1,0,6'h01,32'h0000_0001, 0,7'h00,0));
      apply("to_f3",  mk(1,1,8'h00,1, 1,0,6'h01,32'h0000_0001, 0,7'h00,0));
      apply("to_fwr", mk(1,0,8'h00,1, 0,1,6'h01,32'h0000_0001, 0,7'h00,0));
      apply("to_fend",mk(1,0,8'h00,1, 1,0,6'h01,32'h0000_0001, 0,7'h00,0));

      // Byte arriving on the expiry cycle is taken as data, no timeout.
      apply("tw_hdr", mk(1,1,8'h84,1, 1,0,6'h01,32'h0000_0001, 0,7'h00,0));
      apply("tw_ee",  mk(1,1,8'hEE,1, 1,0,6'h04,32'h0000_0000, 0,7'h00,0));
      for (int k = 0; k < 7; k++)
         apply($sformatf("tw_idle%0d", k), mk(1,0,8'h00,1, 1,0,6'h04,32'h0000_00EE, 0,7'h00,0));
      apply("tw_bb",  mk(1,1,8'hBB,1, 1,0,6'h04,32'h0000_00EE, 0,7'h00,0));
      apply("tw_cc",  mk(1,1,8'hCC,1, 1,0,6'h04,32'h0000_BBEE, 0,7'h00,0));
      apply("tw_dd",  mk(1,1,8'hDD,1, 1,0,6'h04,32'h00CC_BBEE, 0,7'h00,0));
      apply("tw_wr",  mk(1,0,8'h00,1, 0,1,6'h04,32'hDDCC_BBEE, 0,7'h00,0));
      apply("tw_end", mk(1,0,8'h00,1, 1,0,6'h04,32'hDDCC_BBEE, 0,7'h00,0));

      // Reset mid-frame discards the partial frame.
      apply("rs_hdr", mk(1,1,8'h85,1, 1,0,6'h04,32'hDDCC_BBEE, 0,7'h00,0));
      apply("rs_b0",  mk(1,1,8'h78,1, 1,0,6'h05,32'h0000_0000, 0,7'h00,0));
      apply("rs_b1",  mk(1,1,8'h56,1, 1,0,6'h05,32'h0000_0078, 0,7'h00,0));
      apply("rs_rst", mk(0,0,8'h00,1, 1,0,6'h05,32'h0000_5678, 0,7'h00,0));
      apply("rs_h2",  mk(1,1,8'h82,1, 1,0,6'h00,32'h0000_0000, 0,7'h00,0));
      apply("rs_c0",  mk(1,1,8'h04,1, 1,0,6'h02,32'h0000_0000, 0,7'h00,0));
      apply("rs_c1",  mk(1,1,8'h03,1, 1,0,6'h02,32'h0000_0004, 0,7'h00,0));
      apply("rs_c2",  mk(1,1,8'h02,1, 1,0,6'h02,32'h0000_0304, 0,7'h00,0));
      apply("rs_c3",  mk(1,1,8'h01,1, 1,0,6'h02,32'h0002_0304, 0,7'h00,0));
      apply("rs_wr",  mk(1,0,8'h00,1, 0,1,6'h02,32'h0102_0304, 0,7'h00,0));
      apply("rs_end", mk(1,0,8'h00,1, 1,0,6'h02,32'h0102_0304, 0,7'h00,0));

      // Reset while a write is pending drops bus_wvalid with no completion.
      apply("rw_hdr", mk(1,1,8'h87,0, 1,0,6'h02,32'h0102_0304, 0,7'h00,0));
      apply("rw_b0",  mk(1,1,8'h01,0, 1,0,6'h07,32'h0000_0000, 0,7'h00,0));
      apply("rw_b1",  mk(1,1,8'h02,0, 1,0,6'h07,32'h0000_0001, 0,7'h00,0));
      apply("rw_b2",  mk(1,1,8'h03,0, 1,0,6'h07,32'h0000_0201, 0,7'h00,0));
      apply("rw_b3",  mk(1,1,8'h04,0, 1,0,6'h07,32'h0003_0201, 0,7'h00,0));
      apply("rw_pend",mk(1,0,8'h00,0, 0,1,6'h07,32'h0403_0201, 0,7'h00,0));
      apply("rw_rst", mk(0,0,8'h00,0, 0,1,6'h07,32'h0403_0201, 0,7'h00,0));
      apply("rw_clr", mk(1,0,8'h00,1, 1,0,6'h00,32'h0000_0000, 0,7'h00,0));
      apply("rw_idle",mk(1,0,8'h00,1, 1,0,6'h00,32'h0000_0000, 0,7'h00,0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
